// File: rtl/sseg_pkg.sv
// Shared constants for the Nexys3 seven-segment display driver.
// The font is active-low, with dp (bit 7) always off.
package sseg_pkg;

  localparam int unsigned SIG_W = 8;
  localparam int unsigned AN_W  = 4;
  localparam int unsigned BCD_W = 4;

  localparam logic [SIG_W-1:0] SSEG_0     = 8'hC0;
  localparam logic [SIG_W-1:0] SSEG_1     = 8'hF9;
  localparam logic [SIG_W-1:0] SSEG_2     = 8'hA4;
  localparam logic [SIG_W-1:0] SSEG_3     = 8'hB0;
  localparam logic [SIG_W-1:0] SSEG_4     = 8'h99;
  localparam logic [SIG_W-1:0] SSEG_5     = 8'h92;
  localparam logic [SIG_W-1:0] SSEG_6     = 8'h82;
  localparam logic [SIG_W-1:0] SSEG_7     = 8'hF8;
  localparam logic [SIG_W-1:0] SSEG_8     = 8'h80;
  localparam logic [SIG_W-1:0] SSEG_9     = 8'h90;
  localparam logic [SIG_W-1:0] SSEG_BLANK = 8'hFF;

  localparam logic [AN_W-1:0] AN_OFF      = 4'b1111;
  localparam logic [AN_W-1:0] AN_ONES     = 4'b1110;
  localparam logic [AN_W-1:0] AN_TENS     = 4'b1101;
  localparam logic [AN_W-1:0] AN_HUNDREDS = 4'b1011;

  // BCD digit to cathode pattern; non-decimal codes render blank.
  function automatic logic [SIG_W-1:0] seg_font(input logic [BCD_W-1:0] d);
    case (d)
      4'd0:    return SSEG_0;
      4'd1:    return SSEG_1;
      4'd2:    return SSEG_2;
      4'd3:    return SSEG_3;
      4'd4:    return SSEG_4;
      4'd5:    return SSEG_5;
      4'd6:    return SSEG_6;
      4'd7:    return SSEG_7;
      4'd8:    return SSEG_8;
      4'd9:    return SSEG_9;
      default: return SSEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd8.sv
// Combinational 8-bit binary to three BCD digits using shift-add-3.
module bin2bcd8
  import sseg_pkg::*;
(
  input  logic [7:0]       bin,
  output logic [BCD_W-1:0] hundreds_c,
  output logic [BCD_W-1:0] tens_c,
  output logic [BCD_W-1:0] ones_c
);

  localparam int unsigned SR_W = 3 * BCD_W + 8;

  logic [SR_W-1:0] sr;

  // Before each shift, any BCD column >= 5 gets +3 so it carries correctly.
  always_comb begin
    sr = {12'd0, bin};
    for (int i = 0; i < 8; i++) begin
      if (sr[11:8]  >= 4'd5) sr[11:8]  = sr[11:8]  + 4'd3;
      if (sr[15:12] >= 4'd5) sr[15:12] = sr[15:12] + 4'd3;
      if (sr[19:16] >= 4'd5) sr[19:16] = sr[19:16] + 4'd3;
      sr = sr << 1;
    end
  end

  assign hundreds_c = sr[19:16];
  assign tens_c     = sr[15:12];
  assign ones_c     = sr[11:8];

endmodule

// File: rtl/sseg_display.sv
// Four-digit multiplexed decimal display of an 8-bit value with leading-zero
// blanking; slot 3 is always dark.
module sseg_display
  import sseg_pkg::*;
#(
  parameter int unsigned DIV_BITS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       value,
  output logic [AN_W-1:0]  sseg_an,
  output logic [SIG_W-1:0] sseg_sig
);

  localparam int unsigned CNT_W = DIV_BITS + 2;

  logic [CNT_W-1:0] cnt;
  logic [7:0]       value_q;
  logic [1:0]       sel;
  logic [BCD_W-1:0] hundreds_c;
  logic [BCD_W-1:0] tens_c;
  logic [BCD_W-1:0] ones_c;
  logic [AN_W-1:0]  an_c;
  logic [SIG_W-1:0] sig_c;

  assign sel = cnt[CNT_W-1 -: 2];

  bin2bcd8 u_bin2bcd8 (
    .bin        (value_q),
    .hundreds_c (hundreds_c),
    .tens_c     (tens_c),
    .ones_c     (ones_c)
  );

  // Slot mux with leading-zero blanking; anything not lit falls back to blank.
  always_comb begin
    an_c  = AN_OFF;
    sig_c = SSEG_BLANK;
    case (sel)
      2'd0: begin
        an_c  = AN_ONES;
        sig_c = seg_font(ones_c);
      end
      2'd1: begin
        if (value_q >= 8'd10) begin
          an_c  = AN_TENS;
          sig_c = seg_font(tens_c);
        end
      end
      2'd2: begin
        if (value_q >= 8'd100) begin
          an_c  = AN_HUNDREDS;
          sig_c = seg_font(hundreds_c);
        end
      end
      default: begin
        an_c  = AN_OFF;
        sig_c = SSEG_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      value_q  <= '0;
      sseg_an  <= AN_OFF;
      sseg_sig <= SSEG_BLANK;
    end else begin
      cnt      <= cnt + CNT_W'(1);
      value_q  <= value;
      sseg_an  <= an_c;
      sseg_sig <= sig_c;
    end
  end

endmodule

// File: tb/tb_sseg_display.sv
// Scoreboarded random/directed bench for sseg_display with DIV_BITS=2.
module tb_sseg_display;

  localparam int unsigned DIV_BITS = 2;

  logic       clk;
  logic       rst;
  logic [7:0] value;
  logic [3:0] sseg_an;
  logic [7:0] sseg_sig;

  int n_checks = 0;
  int n_pass   = 0;
  bit active   = 0;
  int edge_m;
  int prev_v;
  logic [11:0] exp_q[$];
  logic [7:0]  font[10];

  sseg_display #(.DIV_BITS(DIV_BITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .sseg_an  (sseg_an),
    .sseg_sig (sseg_sig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got an=%b sig=%h, want an=%b sig=%h at %0t",
                  name, act[11:8], act[7:0], exp[11:8], exp[7:0], $time);
  endtask

  // Reference: decimal digits by division, slot chosen by elapsed edges.
  function automatic logic [11:0] expect_out(input int m, input int v);
    int slot;
    slot = ((m - 1) / 4) % 4;
    case (slot)
      0: return {4'b1110, font[v % 10]};
      1: return (v >= 10)  ? {4'b1101, font[(v / 10) % 10]} : 12'hFFF;
      2: return (v >= 100) ? {4'b1011, font[v / 100]} : 12'hFFF;
      default: return 12'hFFF;
    endcase
  endfunction

  // Monitor: compares every edge's outputs against the queued expectation.
  always @(posedge clk) begin
    #1;
    if (active) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard: got an=%b sig=%h, want queued entry (queue empty)",
                 sseg_an, sseg_sig);
      end else begin
        check("scan", {sseg_an, sseg_sig}, exp_q.pop_front());
      end
    end
  end

  // Entered at a negedge; ends at a negedge after n checked edges.
  task automatic run_cycles(input int n, input int v, input bit rnd);
    int nv;
    active = 1;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(expect_out(edge_m, prev_v));
      edge_m++;
      if (rnd) begin
        case ($urandom_range(0, 5))
          0:       nv = prev_v;
          1:       nv = 9 + $urandom_range(0, 1);
          2:       nv = 99 + $urandom_range(0, 1);
          3:       nv = ($urandom_range(0, 1) == 1) ? 0 : 255;
          default: nv = $urandom_range(0, 255);
        endcase
      end else begin
        nv = v;
      end
      value  = 8'(nv);
      prev_v = nv;
      @(posedge clk);
      @(negedge clk);
    end
    active = 0;
  endtask

  // Asynchronous reset from wherever the scan is; ends at a negedge, released.
  task automatic do_reset(input int hold_edges);
    rst = 1'b1;
    #1;
    check("rst_async", {sseg_an, sseg_sig}, 12'hFFF);
    for (int i = 0; i < hold_edges; i++) begin
      @(posedge clk);
      #1;
      check("rst_hold", {sseg_an, sseg_sig}, 12'hFFF);
    end
    @(negedge clk);
    rst    = 1'b0;
    edge_m = 1;
    prev_v = 0;
    exp_q.delete();
  endtask

  initial begin
    font = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    rst    = 1'b1;
    value  = 8'd0;
    edge_m = 1;
    prev_v = 0;

    do_reset(10);
    run_cycles(32, 0, 0);
    run_cycles(40, 255, 0);
    run_cycles(20, 7, 0);
    run_cycles(20, 42, 0);
    run_cycles(20, 100, 0);

    do_reset(2);
    run_cycles(2, 9, 0);
    run_cycles(20, 10, 0);

    do_reset(2);
    run_cycles(6, 123, 0);
    do_reset(3);
    run_cycles(20, 200, 0);

    run_cycles(400, 0, 1);

    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL leftover: got %0d queued entries, want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
